// File: rtl/rice_riscv_inst_matcher_pkg.sv
// Encoding matchers used by the decoder. Every opcode constant ends in 2'b11,
// so any match also implies a 32-bit (non-compressed) encoding.
package rice_riscv_inst_matcher_pkg;

    function automatic logic match_opc(input logic [31:0] inst, input logic [6:0] opc);
        return inst[6:0] == opc;
    endfunction

    function automatic logic match_f3(input logic [31:0] inst, input logic [6:0] opc,
                                      input logic [2:0] f3);
        return (inst[6:0] == opc) && (inst[14:12] == f3);
    endfunction

    function automatic logic match_f7(input logic [31:0] inst, input logic [6:0] opc,
                                      input logic [2:0] f3, input logic [6:0] f7);
        return (inst[6:0] == opc) && (inst[14:12] == f3) && (inst[31:25] == f7);
    endfunction

    function automatic logic match_exact(input logic [31:0] inst, input logic [31:0] pattern);
        return inst == pattern;
    endfunction

endpackage

// File: rtl/rice_riscv_pkg.sv
// Shared RISC-V decode types for the rice core.
//   rice_riscv_inst     : raw 32-bit instruction word
//   rice_riscv_op       : one value per supported instruction plus OP_ILLEGAL
//   rice_riscv_decoded  : decoder result (op, register indices, immediate, illegal flag)
//   rice_skid_state     : occupancy of the decode-stage two-entry skid buffer
package rice_riscv_pkg;

    typedef logic [31:0] rice_riscv_inst;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK, OP_MRET,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ILLEGAL
    } rice_riscv_op;

    typedef struct packed {
        rice_riscv_op op;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [31:0]  imm;
        logic         illegal;
    } rice_riscv_decoded;

    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} rice_skid_state;

    localparam rice_riscv_decoded DECODED_RESET = '{op: OP_ILLEGAL, rd: 5'd0, rs1: 5'd0,
                                                   rs2: 5'd0, imm: 32'd0, illegal: 1'b0};

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/rice_inst_decode_stage_if.sv
// Handshake bundle around the decode stage: fetch->decode request, decode->execute
// result and the pipeline flush. master = surrounding pipeline, slave = decode stage.
interface rice_inst_decode_stage_if
    import rice_riscv_pkg::*;
    #(parameter int XLEN = 32) ();

    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [XLEN-1:0]  if_pc;
    rice_riscv_inst   if_inst;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    rice_riscv_op     id_op;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [31:0]      id_imm;
    logic             id_illegal;

    modport master (output flush, if_valid, if_pc, if_inst, id_ready,
                    input  if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
                           id_imm, id_illegal);

    modport slave  (input  flush, if_valid, if_pc, if_inst, id_ready,
                    output if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
                           id_imm, id_illegal);

endinterface

// File: rtl/rice_inst_decoder.sv
// Combinational RV32I + Zicsr + Zifencei + mret + M decoder.
//   inst : raw instruction word
//   dec  : op, rd/rs1/rs2 (raw fields), immediate, illegal flag
module rice_inst_decoder
    import rice_riscv_pkg::*;
    import rice_riscv_inst_matcher_pkg::*;
(
    input  rice_riscv_inst    inst,
    output rice_riscv_decoded dec
);

    rice_riscv_op op;
    logic [31:0]  imm;

    always_comb begin
        op = OP_ILLEGAL;
        if (match_opc(inst, OPC_LUI))                     op = OP_LUI;
        if (match_opc(inst, OPC_AUIPC))                   op = OP_AUIPC;
        if (match_opc(inst, OPC_JAL))                     op = OP_JAL;
        if (match_f3(inst, OPC_JALR, 3'b000))             op = OP_JALR;
        if (match_f3(inst, OPC_BRANCH, 3'b000))           op = OP_BEQ;
        if (match_f3(inst, OPC_BRANCH, 3'b001))           op = OP_BNE;
        if (match_f3(inst, OPC_BRANCH, 3'b100))           op = OP_BLT;
        if (match_f3(inst, OPC_BRANCH, 3'b101))           op = OP_BGE;
        if (match_f3(inst, OPC_BRANCH, 3'b110))           op = OP_BLTU;
        if (match_f3(inst, OPC_BRANCH, 3'b111))           op = OP_BGEU;
        if (match_f3(inst, OPC_LOAD, 3'b000))             op = OP_LB;
        if (match_f3(inst, OPC_LOAD, 3'b001))             op = OP_LH;
        if (match_f3(inst, OPC_LOAD, 3'b010))             op = OP_LW;
        if (match_f3(inst, OPC_LOAD, 3'b100))             op = OP_LBU;
        if (match_f3(inst, OPC_LOAD, 3'b101))             op = OP_LHU;
        if (match_f3(inst, OPC_STORE, 3'b000))            op = OP_SB;
        if (match_f3(inst, OPC_STORE, 3'b001))            op = OP_SH;
        if (match_f3(inst, OPC_STORE, 3'b010))            op = OP_SW;
        if (match_f3(inst, OPC_OPIMM, 3'b000))            op = OP_ADDI;
        if (match_f3(inst, OPC_OPIMM, 3'b010))            op = OP_SLTI;
        if (match_f3(inst, OPC_OPIMM, 3'b011))            op = OP_SLTIU;
        if (match_f3(inst, OPC_OPIMM, 3'b100))            op = OP_XORI;
        if (match_f3(inst, OPC_OPIMM, 3'b110))            op = OP_ORI;
        if (match_f3(inst, OPC_OPIMM, 3'b111))            op = OP_ANDI;
        // RV32 shift-immediates: shamt[5] must be zero, so imm[11:5] acts as funct7.
        if (match_f7(inst, OPC_OPIMM, 3'b001, F7_BASE))   op = OP_SLLI;
        if (match_f7(inst, OPC_OPIMM, 3'b101, F7_BASE))   op = OP_SRLI;
        if (match_f7(inst, OPC_OPIMM, 3'b101, F7_ALT))    op = OP_SRAI;
        if (match_f7(inst, OPC_OP, 3'b000, F7_BASE))      op = OP_ADD;
        if (match_f7(inst, OPC_OP, 3'b000, F7_ALT))       op = OP_SUB;
        if (match_f7(inst, OPC_OP, 3'b001, F7_BASE))      op = OP_SLL;
        if (match_f7(inst, OPC_OP, 3'b010, F7_BASE))      op = OP_SLT;
        if (match_f7(inst, OPC_OP, 3'b011, F7_BASE))      op = OP_SLTU;
        if (match_f7(inst, OPC_OP, 3'b100, F7_BASE))      op = OP_XOR;
        if (match_f7(inst, OPC_OP, 3'b101, F7_BASE))      op = OP_SRL;
        if (match_f7(inst, OPC_OP, 3'b101, F7_ALT))       op = OP_SRA;
        if (match_f7(inst, OPC_OP, 3'b110, F7_BASE))      op = OP_OR;
        if (match_f7(inst, OPC_OP, 3'b111, F7_BASE))      op = OP_AND;
        if (match_f7(inst, OPC_OP, 3'b000, F7_MULDIV))    op = OP_MUL;
        if (match_f7(inst, OPC_OP, 3'b001, F7_MULDIV))    op = OP_MULH;
        if (match_f7(inst, OPC_OP, 3'b010, F7_MULDIV))    op = OP_MULHSU;
        if (match_f7(inst, OPC_OP, 3'b011, F7_MULDIV))    op = OP_MULHU;
        if (match_f7(inst, OPC_OP, 3'b100, F7_MULDIV))    op = OP_DIV;
        if (match_f7(inst, OPC_OP, 3'b101, F7_MULDIV))    op = OP_DIVU;
        if (match_f7(inst, OPC_OP, 3'b110, F7_MULDIV))    op = OP_REM;
        if (match_f7(inst, OPC_OP, 3'b111, F7_MULDIV))    op = OP_REMU;
        if (match_f3(inst, OPC_MISCMEM, 3'b000))          op = OP_FENCE;
        if (match_f3(inst, OPC_MISCMEM, 3'b001))          op = OP_FENCE_I;
        if (match_exact(inst, 32'h0000_0073))             op = OP_ECALL;
        if (match_exact(inst, 32'h0010_0073))             op = OP_EBREAK;
        if (match_exact(inst, 32'h3020_0073))             op = OP_MRET;
        if (match_f3(inst, OPC_SYSTEM, 3'b001))           op = OP_CSRRW;
        if (match_f3(inst, OPC_SYSTEM, 3'b010))           op = OP_CSRRS;
        if (match_f3(inst, OPC_SYSTEM, 3'b011))           op = OP_CSRRC;
        if (match_f3(inst, OPC_SYSTEM, 3'b101))           op = OP_CSRRWI;
        if (match_f3(inst, OPC_SYSTEM, 3'b110))           op = OP_CSRRSI;
        if (match_f3(inst, OPC_SYSTEM, 3'b111))           op = OP_CSRRCI;
    end

    always_comb begin
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
            OPC_JAL:            imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_BRANCH:         imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_STORE:          imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
            OPC_OP:             imm = 32'd0;
            // funct3[2] selects the CSR-immediate forms, whose operand is zimm in rs1.
            OPC_SYSTEM:         imm = inst[14] ? {27'd0, inst[19:15]}
                                               : {{21{inst[31]}}, inst[30:20]};
            default:            imm = {{21{inst[31]}}, inst[30:20]};
        endcase
        if (op == OP_ILLEGAL) imm = 32'd0;
    end

    always_comb begin
        dec         = DECODED_RESET;
        dec.op      = op;
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.imm     = imm;
        dec.illegal = (op == OP_ILLEGAL);
    end

endmodule

// File: rtl/rice_inst_decode_stage.sv
// Registered decode stage with a two-entry skid buffer so o_if_ready is a flop.
//   i_clk, i_rst               : clock, async active-high reset
//   i_flush                    : redirect; drops every buffered and incoming entry
//   i_if_valid/o_if_ready      : fetch handshake carrying i_if_pc, i_if_inst
//   o_id_valid/i_id_ready      : execute handshake carrying o_id_* decode results
//
// state    | meaning
// EMPTY    | no entry held; ready=1, valid=0
// BUSY     | main entry holds the presented result; ready=1, valid=1
// FULL     | main and skid both hold entries; ready=0, valid=1
module rice_inst_decode_stage
    import rice_riscv_pkg::*;
    #(parameter int XLEN = 32)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_if_valid,
    output logic             o_if_ready,
    input  logic [XLEN-1:0]  i_if_pc,
    input  rice_riscv_inst   i_if_inst,
    output logic             o_id_valid,
    input  logic             i_id_ready,
    output logic [XLEN-1:0]  o_id_pc,
    output rice_riscv_op     o_id_op,
    output logic [4:0]       o_id_rd,
    output logic [4:0]       o_id_rs1,
    output logic [4:0]       o_id_rs2,
    output logic [31:0]      o_id_imm,
    output logic             o_id_illegal
);

    rice_riscv_decoded dec_new;
    rice_riscv_decoded main_q, main_d, skid_q, skid_d;
    logic [XLEN-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    rice_skid_state    state_q, state_d;
    logic              if_ready_q, if_ready_d, id_valid_q, id_valid_d;
    logic              do_in, do_out;

    rice_inst_decoder u_decoder (
        .inst (i_if_inst),
        .dec  (dec_new)
    );

    assign do_in  = i_if_valid && if_ready_q;
    assign do_out = id_valid_q && i_id_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        main_pc_d = main_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        case (state_q)
            ST_EMPTY: begin
                if (do_in) begin
                    main_d    = dec_new;
                    main_pc_d = i_if_pc;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (do_in && do_out) begin
                    main_d    = dec_new;
                    main_pc_d = i_if_pc;
                end else if (do_in) begin
                    skid_d    = dec_new;
                    skid_pc_d = i_if_pc;
                    state_d   = ST_FULL;
                end else if (do_out) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (do_out) begin
                    main_d    = skid_q;
                    main_pc_d = skid_pc_q;
                    state_d   = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (i_flush) state_d = ST_EMPTY;
        // Handshake outputs are registered copies of the next-state decode.
        if_ready_d = (state_d != ST_FULL);
        id_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= DECODED_RESET;
            main_pc_q  <= '0;
            skid_q     <= DECODED_RESET;
            skid_pc_q  <= '0;
            if_ready_q <= 1'b1;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_pc_q  <= main_pc_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            if_ready_q <= if_ready_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign o_if_ready   = if_ready_q;
    assign o_id_valid   = id_valid_q;
    assign o_id_pc      = main_pc_q;
    assign o_id_op      = main_q.op;
    assign o_id_rd      = main_q.rd;
    assign o_id_rs1     = main_q.rs1;
    assign o_id_rs2     = main_q.rs2;
    assign o_id_imm     = main_q.imm;
    assign o_id_illegal = main_q.illegal;

endmodule
